// File: rtl/pipe_adder_if.sv
// Valid/ready operand and result channel of pipe_adder.
// The slave modport is the adder; the master modport is the producer/consumer side.
interface pipe_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout
    );

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout
    );
endinterface

// File: rtl/pipe_adder.sv
// Segment-pipelined adder: one SEG-bit slice per stage, carry registered between stages.
// Optional subtract support is built when PIPE_ADDER_SUB_EN is defined.
module pipe_adder #(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input logic        clk,
    input logic        rst_n,
    pipe_adder_if.slave bus
);
    localparam int N = WIDTH / SEG;

    if (SEG < 1 || WIDTH < SEG || (WIDTH % SEG) != 0) begin : g_bad_geometry
        $error("pipe_adder: WIDTH must be a non-zero integer multiple of SEG");
    end

    logic adv;

    // Per-stage state; opa/opb carry the not-yet-added upper segments forward.
    logic [N-1:0]     vld;
    logic [N-1:0]     cry;
    logic [WIDTH-1:0] res [N];
    logic [WIDTH-1:0] opa [N];
    logic [WIDTH-1:0] opb [N];

    logic [N-1:0]     src_v;
    logic [N-1:0]     src_c;
    logic [WIDTH-1:0] src_a   [N];
    logic [WIDTH-1:0] src_b   [N];
    logic [WIDTH-1:0] src_res [N];
    logic [WIDTH-1:0] nxt_res [N];
    logic [SEG-1:0]   b_eff   [N];
    logic [SEG:0]     seg_add [N];

`ifdef PIPE_ADDER_SUB_EN
    logic [N-1:0] sb;
    logic [N-1:0] src_s;
`endif

    assign adv          = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = adv;
    assign bus.out_valid = vld[N-1];
    assign bus.sum       = res[N-1];
    assign bus.cout      = cry[N-1];

    always_comb begin
        // NOTE: every always_comb output gets a value on every path first, so no latch is inferred.
        src_v[0]   = bus.in_valid;
        src_a[0]   = bus.a;
        src_b[0]   = bus.b;
        src_c[0]   = bus.cin;
        src_res[0] = '0;
`ifdef PIPE_ADDER_SUB_EN
        src_s[0] = bus.sub;
        if (bus.sub) begin
            src_c[0] = 1'b1;
        end
`endif
        for (int k = 1; k < N; k++) begin
            src_v[k]   = vld[k-1];
            src_a[k]   = opa[k-1];
            src_b[k]   = opb[k-1];
            src_c[k]   = cry[k-1];
            src_res[k] = res[k-1];
`ifdef PIPE_ADDER_SUB_EN
            src_s[k] = sb[k-1];
`endif
        end

        // Each stage adds only its own slice; the carry in comes from a register.
        for (int k = 0; k < N; k++) begin
            b_eff[k] = src_b[k][k*SEG +: SEG];
`ifdef PIPE_ADDER_SUB_EN
            if (src_s[k]) begin
                b_eff[k] = ~b_eff[k];
            end
`endif
            seg_add[k] = {1'b0, src_a[k][k*SEG +: SEG]} + {1'b0, b_eff[k]}
                       + {{SEG{1'b0}}, src_c[k]};
            nxt_res[k] = src_res[k];
            nxt_res[k][k*SEG +: SEG] = seg_add[k][SEG-1:0];
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: only the valid bits and the visible result are reset; the inner datapath
        // is qualified by its valid bit and needs no reset.
        if (!rst_n) begin
            vld      <= '0;
            cry[N-1] <= 1'b0;
            res[N-1] <= '0;
        end else if (adv) begin
            for (int k = 0; k < N; k++) begin
                vld[k] <= src_v[k];
                // Data moves only with a real operation, so sum/cout hold across bubbles.
                if (src_v[k]) begin
                    res[k] <= nxt_res[k];
                    cry[k] <= seg_add[k][SEG];
                    if (k < N - 1) begin
                        opa[k] <= src_a[k];
                        opb[k] <= src_b[k];
                    end
`ifdef PIPE_ADDER_SUB_EN
                    sb[k] <= src_s[k];
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder: directed carry/throughput/stall/reset steps
// plus randomized traffic scored against an arithmetic reference model.
module tb_pipe_adder;
    parameter int WIDTH = 32;
    parameter int SEG   = 8;
    localparam int N = WIDTH / SEG;
`ifdef PIPE_ADDER_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pipe_adder_if #(.WIDTH(WIDTH)) bus ();

    pipe_adder #(.WIDTH(WIDTH), .SEG(SEG)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [WIDTH:0] q [$];
    int             take_log [$];
    int             n_vec = 0;
    int             n_err = 0;
    int             cyc   = 0;

    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic cin, input logic sub);
        if (sub) return {(a >= b), WIDTH'(a - b)};
        return {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
    endfunction

    function automatic logic [WIDTH-1:0] rnd();
        return WIDTH'({$urandom, $urandom});
    endfunction

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes just before the rising edge, score, return at next negedge.
    task automatic cycle(output logic acc);
        logic take;
        #1;
        acc  = bus.in_valid && bus.in_ready;
        take = bus.out_valid && bus.out_ready;
        check("in_ready_rule", bus.in_ready, !bus.out_valid || bus.out_ready);
        if (take) begin
            take_log.push_back(cyc);
            check("out_expected", q.size() > 0, 1'b1);
            if (q.size() > 0) check("result", {bus.cout, bus.sum}, q.pop_front());
        end
        if (acc) q.push_back(model(bus.a, bus.b, bus.cin, bus.sub && SUB_EN));
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain();
        logic acc;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int w = 0; w < 4 * N + 8 && q.size() > 0; w++) cycle(acc);
        check("drain_empty", q.size(), 0);
    endtask

    task automatic push_rand(input int count);
        logic acc;
        for (int i = 0; i < count; i++) begin
            bus.in_valid = 1'b1;
            bus.a        = rnd();
            bus.b        = rnd();
            bus.cin      = 1'($urandom_range(1));
            bus.sub      = 1'b0;
            cycle(acc);
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic           acc;
        logic [WIDTH:0] exp_front;
        int             rem;
        int             accepted;

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_sum", bus.sum, 0);
        check("rst_cout", bus.cout, 0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", bus.in_ready, 1);
        @(negedge clk);

        // Carry ripple through every stage: all-ones + 1
        bus.a        = '1;
        bus.b        = WIDTH'(1);
        bus.cin      = 1'b0;
        bus.in_valid = 1'b1;
        #1;
        check("ripple_in_ready", bus.in_ready, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int j = 0; j < N - 1; j++) begin
            check("ripple_early", bus.out_valid, 0);
            @(negedge clk);
        end
        check("ripple_valid", bus.out_valid, 1);
        check("ripple_sum", bus.sum, 0);
        check("ripple_cout", bus.cout, 1);
        @(negedge clk);
        check("ripple_one_cycle", bus.out_valid, 0);

        // Throughput: 16 back-to-back operations
        take_log.delete();
        for (int i = 0; i < 16; i++) begin
            bus.in_valid  = 1'b1;
            bus.out_ready = 1'b1;
            bus.a         = WIDTH'(i);
            bus.b         = WIDTH'(64'h1000_0000 * 64'(i));
            bus.cin       = i[0];
            bus.sub       = 1'b0;
            cycle(acc);
            check("tp_accept", acc, 1);
        end
        drain();
        check("tp_count", take_log.size(), 16);
        if (take_log.size() == 16) check("tp_back_to_back", take_log[15] - take_log[0], 15);

        // Backpressure: four in flight, three stalled cycles
        bus.out_ready = 1'b1;
        push_rand(4);
        bus.out_ready = 1'b0;
        for (int w = 0; w < 4 * N && !bus.out_valid; w++) cycle(acc);
        check("bp_full", bus.out_valid, 1);
        for (int s = 0; s < 3; s++) begin
            exp_front = (q.size() > 0) ? q[0] : 'x;
            #1;
            check("bp_in_ready", bus.in_ready, 0);
            cycle(acc);
            check("bp_hold_valid", bus.out_valid, 1);
            check("bp_hold_data", {bus.cout, bus.sum}, exp_front);
        end
        rem = q.size();
        take_log.delete();
        drain();
        check("bp_remaining", take_log.size(), rem);
        if (take_log.size() > 0)
            check("bp_one_per_cycle", take_log[take_log.size()-1] - take_log[0], take_log.size() - 1);

        // Reset with operations in flight
        bus.out_ready = 1'b1;
        push_rand(3);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        check("mid_rst_valid", bus.out_valid, 0);
        check("mid_rst_sum", bus.sum, 0);
        check("mid_rst_cout", bus.cout, 0);
        for (int i = 0; i < 8; i++) begin
            check("mid_rst_no_stale", bus.out_valid, 0);
            @(negedge clk);
        end

`ifdef PIPE_ADDER_SUB_EN
        // Subtract with and without borrow
        bus.in_valid = 1'b1;
        bus.sub      = 1'b1;
        bus.cin      = 1'b0;
        bus.a        = WIDTH'(5);
        bus.b        = WIDTH'(7);
        cycle(acc);
        bus.a        = WIDTH'(7);
        bus.b        = WIDTH'(5);
        bus.cin      = 1'b1;
        cycle(acc);
        bus.sub      = 1'b0;
        drain();
`endif

        // Randomized traffic with random backpressure
        accepted = 0;
        for (int c = 0; c < 20000 && accepted < 1000; c++) begin
            bus.in_valid  = ($urandom_range(3) != 0);
            bus.a         = rnd();
            bus.b         = rnd();
            bus.cin       = 1'($urandom_range(1));
            bus.sub       = 1'($urandom_range(1));
            bus.out_ready = 1'($urandom_range(1));
            cycle(acc);
            if (acc) accepted++;
        end
        check("rand_accepted", accepted, 1000);
        bus.sub = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
